// File: rtl/multdiv_scheduler.sv
// Sequences the shared iterative mult/div unit: launches one op, tracks its
// pending destination for decode hazards, and arbitrates the regfile write port.
module multdiv_scheduler #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_is_div,
  input  logic [4:0]        issue_rd,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  output logic              issue_stall,
  input  logic [4:0]        d_rs,
  input  logic [4:0]        d_rt,
  output logic              hazard_stall,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operand_a,
  output logic [DATA_W-1:0] md_operand_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_ready,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_wb_hold,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              timeout
);
  localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]        RSTATUS  = 5'd30;
  localparam logic [DATA_W-1:0] EXC_MULT = DATA_W'(4);
  localparam logic [DATA_W-1:0] EXC_DIV  = DATA_W'(5);

  typedef enum logic [1:0] {IDLE, START, RUN, WRITE} state_t;

  state_t            r_state;
  logic              r_is_div;
  logic [4:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mult_pulse;
  logic              r_div_pulse;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_wr_we;
  logic [4:0]        r_wr_rd;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_timeout;

  logic              w_own_port;
  logic              w_pipe_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_is_div     <= 1'b0;
      r_rd         <= 5'd0;
      r_cnt        <= '0;
      r_mult_pulse <= 1'b0;
      r_div_pulse  <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_wr_we      <= 1'b0;
      r_wr_rd      <= 5'd0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_mult_pulse <= 1'b0;
      r_div_pulse  <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (issue_valid) begin
            r_is_div     <= issue_is_div;
            r_rd         <= issue_rd;
            r_op_a       <= issue_a;
            r_op_b       <= issue_b;
            r_mult_pulse <= !issue_is_div;
            r_div_pulse  <= issue_is_div;
            r_busy       <= 1'b1;
            r_state      <= START;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A ready on the last allowed cycle still wins over the watchdog.
          if (md_ready) begin
            r_state <= WRITE;
            if (md_exception) begin
              r_wr_we   <= 1'b1;
              r_wr_rd   <= RSTATUS;
              r_wr_data <= r_is_div ? EXC_DIV : EXC_MULT;
            end else begin
              r_wr_we   <= (r_rd != 5'd0);
              r_wr_rd   <= r_rd;
              r_wr_data <= md_result;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        WRITE: begin
          r_wr_we <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign md_ctrl_mult = r_mult_pulse;
  assign md_ctrl_div  = r_div_pulse;
  assign md_operand_a = r_op_a;
  assign md_operand_b = r_op_b;
  assign busy         = r_busy;
  assign timeout      = r_timeout;

  assign issue_stall  = issue_valid && (r_state != IDLE);
  // Regfile writes through on the falling edge, so WRITE needs no stall.
  assign hazard_stall = ((r_state == START) || (r_state == RUN)) && (r_rd != 5'd0) &&
                        ((d_rs == r_rd) || (d_rt == r_rd));

  assign w_own_port   = (r_state == WRITE);
  assign w_pipe_ok    = reset && pipe_we && (pipe_rd != 5'd0);
  assign pipe_wb_hold = w_own_port && pipe_we;
  assign wb_we        = w_own_port ? r_wr_we   : w_pipe_ok;
  assign wb_rd        = w_own_port ? r_wr_rd   : (reset ? pipe_rd : 5'd0);
  assign wb_data      = w_own_port ? r_wr_data : (reset ? pipe_data : '0);
endmodule

// File: tb/tb_multdiv_scheduler.sv
// Directed bench for multdiv_scheduler: table of complete ops plus hand-written
// sequences for hazards, port conflicts, back-to-back issue, watchdog and reset.
module tb_multdiv_scheduler;
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a, issue_b;
  logic        issue_stall;
  logic [4:0]  d_rs, d_rt;
  logic        hazard_stall;
  logic        md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_wb_hold;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multdiv_scheduler #(.DATA_W(32), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b), .issue_stall(issue_stall),
    .d_rs(d_rs), .d_rt(d_rt), .hazard_stall(hazard_stall),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_wb_hold(pipe_wb_hold),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        exc;
    int          delay;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic is_div, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1; issue_is_div = is_div; issue_rd = rd; issue_a = a; issue_b = b;
    tick();
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = 5'd0; issue_a = '0; issue_b = '0;
    #1;
  endtask

  task automatic finish_op(input logic [31:0] result, input logic exc);
    md_ready = 1'b1; md_result = result; md_exception = exc;
    tick();
    md_ready = 1'b0; md_result = '0; md_exception = 1'b0;
    #1;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    issue(v.is_div, v.rd, v.a, v.b);
    check($sformatf("v%0d.mult_pulse", idx), {31'd0, md_ctrl_mult}, {31'd0, !v.is_div});
    check($sformatf("v%0d.div_pulse", idx), {31'd0, md_ctrl_div}, {31'd0, v.is_div});
    check($sformatf("v%0d.op_a", idx), md_operand_a, v.a);
    check($sformatf("v%0d.op_b", idx), md_operand_b, v.b);
    check($sformatf("v%0d.busy_start", idx), {31'd0, busy}, 32'd1);
    tick();
    check($sformatf("v%0d.pulse_gone", idx), {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    for (int i = 0; i < v.delay; i++) tick();
    finish_op(v.result, v.exc);
    check($sformatf("v%0d.wb_we", idx), {31'd0, wb_we}, {31'd0, v.exp_we});
    if (v.exp_we) begin
      check($sformatf("v%0d.wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.exp_rd});
      check($sformatf("v%0d.wb_data", idx), wb_data, v.exp_data);
    end
    check($sformatf("v%0d.busy_write", idx), {31'd0, busy}, 32'd1);
    tick();
    check($sformatf("v%0d.we_one_cycle", idx), {31'd0, wb_we}, 32'd0);
    check($sformatf("v%0d.busy_drop", idx), {31'd0, busy}, 32'd0);
    $display("op %0d div=%0d rd=%0d delay=%0d -> we=%0d rd=%0d data=%0h",
             idx, v.is_div, v.rd, v.delay, v.exp_we, v.exp_rd, v.exp_data);
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = 5'd0; issue_a = '0; issue_b = '0;
    d_rs = 5'd0; d_rt = 5'd0;
    md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
    pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = '0;

    vecs[0] = '{1'b0, 5'd5,  32'd7,   32'd6, 32'd42,         1'b0, 32, 1'b1, 5'd5,  32'd42};
    vecs[1] = '{1'b1, 5'd7,  32'd10,  32'd0, 32'h0,          1'b1, 3,  1'b1, 5'd30, 32'd5};
    vecs[2] = '{1'b0, 5'd9,  32'hFFFF_FFFF, 32'd2, 32'h1234, 1'b1, 0,  1'b1, 5'd30, 32'd4};
    vecs[3] = '{1'b1, 5'd12, 32'd100, 32'd7, 32'd14,         1'b0, 63, 1'b1, 5'd12, 32'd14};
    vecs[4] = '{1'b0, 5'd0,  32'd5,   32'd11, 32'd55,        1'b0, 1,  1'b0, 5'd0,  32'd0};
    vecs[5] = '{1'b1, 5'd0,  32'd1,   32'd0, 32'd0,          1'b1, 2,  1'b1, 5'd30, 32'd5};
    vecs[6] = '{1'b0, 5'd31, 32'd3,   32'd5, 32'hFFFF_FFFF,  1'b0, 5,  1'b1, 5'd31, 32'hFFFF_FFFF};

    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.wb_we", {31'd0, wb_we}, 32'd0);
    check("rst.pulses", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    check("rst.op_a", md_operand_a, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_op(vecs[i], i);

    // Hazard tracking against the pending rd=8.
    d_rs = 5'd8;
    issue(1'b0, 5'd8, 32'd2, 32'd3);
    check("haz.start", {31'd0, hazard_stall}, 32'd1);
    tick();
    check("haz.run_rs", {31'd0, hazard_stall}, 32'd1);
    d_rs = 5'd9; d_rt = 5'd8; #1;
    check("haz.run_rt", {31'd0, hazard_stall}, 32'd1);
    d_rt = 5'd1; #1;
    check("haz.run_nomatch", {31'd0, hazard_stall}, 32'd0);
    d_rs = 5'd8; tick();
    check("haz.run_late", {31'd0, hazard_stall}, 32'd1);
    finish_op(32'd6, 1'b0);
    check("haz.write", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("haz.idle", {31'd0, hazard_stall}, 32'd0);
    d_rs = 5'd0; d_rt = 5'd0;
    issue(1'b0, 5'd0, 32'd2, 32'd3);
    check("haz0.start", {31'd0, hazard_stall}, 32'd0);
    tick();
    check("haz0.run", {31'd0, hazard_stall}, 32'd0);
    finish_op(32'd6, 1'b0);
    tick();
    $display("hazard sequence done");

    // Port conflict: multdiv write wins, pipe write re-presented next cycle.
    issue(1'b0, 5'd4, 32'd7, 32'd11);
    tick();
    finish_op(32'd77, 1'b0);
    pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'd9; #1;
    check("port.hold", {31'd0, pipe_wb_hold}, 32'd1);
    check("port.md_we", {31'd0, wb_we}, 32'd1);
    check("port.md_rd", {27'd0, wb_rd}, 32'd4);
    check("port.md_data", wb_data, 32'd77);
    tick();
    check("port.hold_off", {31'd0, pipe_wb_hold}, 32'd0);
    check("port.pipe_we", {31'd0, wb_we}, 32'd1);
    check("port.pipe_rd", {27'd0, wb_rd}, 32'd3);
    check("port.pipe_data", wb_data, 32'd9);
    pipe_rd = 5'd0; #1;
    check("port.rd0_nowrite", {31'd0, wb_we}, 32'd0);
    pipe_we = 1'b0; pipe_data = '0;
    $display("port conflict sequence done");

    // Second issue while RUN waits for IDLE and launches with its own operands.
    issue(1'b0, 5'd2, 32'd3, 32'd4);
    tick();
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd6; issue_a = 32'd50; issue_b = 32'd5; #1;
    check("b2b.stall_run", {31'd0, issue_stall}, 32'd1);
    tick();
    check("b2b.no_pulse", {30'd0, md_ctrl_mult, md_ctrl_div}, 32'd0);
    check("b2b.op_a_kept", md_operand_a, 32'd3);
    finish_op(32'd12, 1'b0);
    check("b2b.stall_write", {31'd0, issue_stall}, 32'd1);
    check("b2b.first_data", wb_data, 32'd12);
    tick();
    check("b2b.stall_idle", {31'd0, issue_stall}, 32'd0);
    tick();
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = 5'd0; issue_a = '0; issue_b = '0; #1;
    check("b2b.div_pulse", {31'd0, md_ctrl_div}, 32'd1);
    check("b2b.op_a", md_operand_a, 32'd50);
    check("b2b.op_b", md_operand_b, 32'd5);
    tick();
    finish_op(32'd10, 1'b0);
    check("b2b.second_rd", {27'd0, wb_rd}, 32'd6);
    check("b2b.second_data", wb_data, 32'd10);
    tick();
    $display("back-to-back sequence done");

    // Watchdog: 64 RUN cycles without ready.
    issue(1'b1, 5'd14, 32'd9, 32'd3);
    tick();
    for (int i = 0; i < 63; i++) tick();
    check("wd.busy_last", {31'd0, busy}, 32'd1);
    check("wd.no_early", {31'd0, timeout}, 32'd0);
    tick();
    check("wd.pulse", {31'd0, timeout}, 32'd1);
    check("wd.busy", {31'd0, busy}, 32'd0);
    check("wd.no_write", {31'd0, wb_we}, 32'd0);
    md_ready = 1'b1; md_result = 32'd99;
    tick();
    check("wd.pulse_once", {31'd0, timeout}, 32'd0);
    check("wd.ready_ignored_we", {31'd0, wb_we}, 32'd0);
    check("wd.ready_ignored_busy", {31'd0, busy}, 32'd0);
    md_ready = 1'b0; md_result = '0;
    $display("watchdog sequence done");

    // Asynchronous reset in the middle of RUN.
    d_rs = 5'd17;
    issue(1'b0, 5'd17, 32'd8, 32'd8);
    tick(); tick();
    issue_valid = 1'b1; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'd9; #1;
    check("ar.pre_hazard", {31'd0, hazard_stall}, 32'd1);
    #1 reset = 1'b0; #1;
    check("ar.busy", {31'd0, busy}, 32'd0);
    check("ar.issue_stall", {31'd0, issue_stall}, 32'd0);
    check("ar.hazard", {31'd0, hazard_stall}, 32'd0);
    check("ar.op_a", md_operand_a, 32'd0);
    check("ar.wb", {wb_we, wb_rd, wb_data[25:0]}, 32'd0);
    check("ar.hold", {31'd0, pipe_wb_hold}, 32'd0);
    issue_valid = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = '0; d_rs = 5'd0;
    tick();
    reset = 1'b1;
    md_ready = 1'b1; md_result = 32'd64;
    tick();
    check("ar.discard_we", {31'd0, wb_we}, 32'd0);
    check("ar.stay_idle", {31'd0, busy}, 32'd0);
    md_ready = 1'b0; md_result = '0;
    $display("async reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
